reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer at the receiving end of the reservation-station/ALU result path.
- Allocates one tag per decoded instruction and captures out-of-order writeback results by tag.
- Retires entries strictly in program order.
- Each retirement is broadcast as a one-cycle commit pulse. The reservation stations use it to clear renaming, and the register file uses it to write rd.

Parameters:
- ROB_DEPTH, 16, number of entries; power of two.
- ROB_IDX_W, 4, tag width; log2(ROB_DEPTH).
- DATA_W, 32, result width.
- REG_IDX_W, 5, architectural register index width.
- ADDR_W, 32, pc width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- clr  in  1  synchronous flush (misprediction); high for one or more cycles.
- alloc_valid  in  1  decoder requests a new entry.
- alloc_rd  in  REG_IDX_W  destination register of the new entry.
- alloc_pc  in  ADDR_W  pc of the new entry.
- alloc_tag  out  ROB_IDX_W  tag the next accepted allocation receives (= tail).
- rob_full  out  1  count == ROB_DEPTH; decoder/IF must stall.
- rob_empty  out  1  count == 0.
- wb_valid  in  1  result broadcast from ALU/LSB.
- wb_tag  in  ROB_IDX_W  entry being completed.
- wb_value  in  DATA_W  result value.
- q1_tag, q2_tag  in  ROB_IDX_W  operand lookup tags from dispatch.
- q1_ready, q2_ready  out  1  addressed entry busy and result present.
- q1_value, q2_value  out  DATA_W  stored result of addressed entry.
- commit_valid  out  1  registered one-cycle retire pulse.
- commit_tag  out  ROB_IDX_W  tag of retired entry.
- commit_rd  out  REG_IDX_W  destination of retired entry.
- commit_value  out  DATA_W  value of retired entry.
- commit_pc  out  ADDR_W  pc of retired entry.

Behaviour:
- State per entry: busy, done, rd, value, pc. Global state: head, tail (ROB_IDX_W, natural wrap), count (ROB_IDX_W+1 bits, 0..ROB_DEPTH).
- Reset (rst low, asynchronous): head=tail=count=0; all busy/done=0; commit_* = 0; rob_empty=1, rob_full=0, alloc_tag=0.
- Priority per edge: rst > clr > (rdy low: hold everything, commit_valid<=0) > normal operation.
- clr with rdy high: all busy/done cleared; head=tail=count=0; commit_valid<=0. Same-cycle alloc, wb and commit are discarded.
- Allocate:
  - Accepted when alloc_valid && !rob_full.
  - Entry[tail] gets busy=1, done=0, rd and pc latched.
  - tail<=tail+1 (mod ROB_DEPTH).
  - alloc_tag and rob_full are combinational from current registers; allocation is visible the next cycle.
- Full test uses pre-edge count. When count==ROB_DEPTH, allocation is refused even if a commit happens the same cycle.
- Writeback:
  - If wb_valid and entry[wb_tag].busy: done<=1 and value<=wb_value.
  - Writeback to a non-busy entry is ignored.
  - A repeated writeback overwrites value.
- Commit:
  - Fires when entry[head].busy && entry[head].done, using pre-edge state.
  - Next cycle: commit_valid=1, commit_tag=head, and commit_rd/value/pc come from the entry.
  - On the same edge: entry busy/done<=0, head<=head+1.
  - At most one commit per cycle.
  - commit_valid is 0 in any cycle following an edge with no commit.
  - commit_* data fields hold their last value when commit_valid=0.
- A writeback to the head entry commits on the following edge, so minimum wb-to-commit_valid latency is 2 cycles.
- rd==0 still commits normally with commit_rd=0; consumers ignore it.
- count update: +1 on allocate, -1 on commit, unchanged when both or neither occur.
- Query ports are combinational reads of registered state.
  - q_ready = busy && done.
  - q_value = stored value. It is don't-care when q_ready=0; the implementation drives 0.

Optional Feature:
- Macro: ROB_QUERY_BYPASS_EN.
- Defined: if wb_valid and wb_tag==qN_tag and the entry is busy, qN_ready=1 and qN_value=wb_value in the same cycle, so dispatch sees a result without waiting a cycle.
- Undefined: query ports reflect registered state only, and a result becomes visible one cycle after writeback.

Test Plan:
- After reset, alloc rd=5 pc=0x100 then rd=6 pc=0x104 -> tags 0,1; count=2, rob_empty=0.
- wb tag1=0xAA, then one cycle later wb tag0=0x55 -> commit_valid on two consecutive cycles:
  - first: tag0, rd=5, value 0x55
  - then: tag1, rd=6, value 0xAA
- Fill 16 entries -> rob_full=1, and the 17th alloc is ignored with tail unchanged. After head is written back and commits, rob_full drops and the next alloc gets tag 0 (wrap).
- With 3 entries live and entry 1 done, pulse clr -> rob_empty=1 next cycle, no commit_valid, and the next alloc gets tag 0.
- Hold rdy=0 while the head entry is done -> no commit and pointers frozen. When rdy=1 is restored, commit_valid appears on the next edge.
- wb tag2=0x1234 with q1_tag=2:
  - bypass defined: q1_ready=1, q1_value=0x1234 in the same cycle.
  - bypass undefined: q1_ready=0 that cycle and 1 on the next.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags, captures out-of-order writebacks, retires in order.
// Optional same-cycle writeback-to-query forwarding is enabled by defining ROB_QUERY_BYPASS_EN.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 alloc_valid,
  input  logic [REG_IDX_W-1:0] alloc_rd,
  input  logic [ADDR_W-1:0]    alloc_pc,
  output logic [ROB_IDX_W-1:0] alloc_tag,
  output logic                 rob_full,
  output logic                 rob_empty,
  input  logic                 wb_valid,
  input  logic [ROB_IDX_W-1:0] wb_tag,
  input  logic [DATA_W-1:0]    wb_value,
  input  logic [ROB_IDX_W-1:0] q1_tag,
  input  logic [ROB_IDX_W-1:0] q2_tag,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [DATA_W-1:0]    q1_value,
  output logic [DATA_W-1:0]    q2_value,
  output logic                 commit_valid,
  output logic [ROB_IDX_W-1:0] commit_tag,
  output logic [REG_IDX_W-1:0] commit_rd,
  output logic [DATA_W-1:0]    commit_value,
  output logic [ADDR_W-1:0]    commit_pc
);

  localparam logic [ROB_IDX_W:0]   FULL_CNT = (ROB_IDX_W+1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_W-1:0] IDX_ONE  = {{(ROB_IDX_W-1){1'b0}}, 1'b1};
  localparam logic [ROB_IDX_W:0]   CNT_ONE  = {{ROB_IDX_W{1'b0}}, 1'b1};

  logic [ROB_DEPTH-1:0] busy_q, busy_d, done_q, done_d;
  logic [REG_IDX_W-1:0] rd_q    [ROB_DEPTH];
  logic [REG_IDX_W-1:0] rd_d    [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q [ROB_DEPTH];
  logic [DATA_W-1:0]    value_d [ROB_DEPTH];
  logic [ADDR_W-1:0]    pc_q    [ROB_DEPTH];
  logic [ADDR_W-1:0]    pc_d    [ROB_DEPTH];
  logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_IDX_W:0]   count_q, count_d;
  logic                 commit_valid_q, commit_valid_d;
  logic [ROB_IDX_W-1:0] commit_tag_q, commit_tag_d;
  logic [REG_IDX_W-1:0] commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]    commit_value_q, commit_value_d;
  logic [ADDR_W-1:0]    commit_pc_q, commit_pc_d;

  logic alloc_fire, wb_fire, commit_fire;

  assign rob_full    = (count_q == FULL_CNT);
  assign rob_empty   = (count_q == '0);
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid && !rob_full;
  assign wb_fire     = wb_valid && busy_q[wb_tag];
  assign commit_fire = busy_q[head_q] && done_q[head_q];

  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign commit_pc    = commit_pc_q;

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    rd_d           = rd_q;
    value_d        = value_q;
    pc_d           = pc_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_tag_d   = commit_tag_q;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_pc_d    = commit_pc_q;
    if (clr) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      if (wb_fire) begin
        done_d[wb_tag]  = 1'b1;
        value_d[wb_tag] = wb_value;
      end
      // Commit data comes from pre-edge state, so a same-cycle writeback to head cannot leak in.
      if (commit_fire) begin
        commit_valid_d  = 1'b1;
        commit_tag_d    = head_q;
        commit_rd_d     = rd_q[head_q];
        commit_value_d  = value_q[head_q];
        commit_pc_d     = pc_q[head_q];
        busy_d[head_q]  = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + IDX_ONE;
      end
      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        rd_d[tail_q]   = alloc_rd;
        pc_d[tail_q]   = alloc_pc;
        tail_d         = tail_q + IDX_ONE;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q         <= '0;
      done_q         <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_pc_q    <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      pc_q           <= pc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_pc_q    <= commit_pc_d;
    end
  end

  always_comb begin
    q1_ready = busy_q[q1_tag] && done_q[q1_tag];
    q2_ready = busy_q[q2_tag] && done_q[q2_tag];
    q1_value = q1_ready ? value_q[q1_tag] : '0;
    q2_value = q2_ready ? value_q[q2_tag] : '0;
`ifdef ROB_QUERY_BYPASS_EN
    // Forward the in-flight writeback so dispatch does not wait a cycle.
    if (wb_valid && busy_q[wb_tag] && (wb_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_value = wb_value;
    end
    if (wb_valid && busy_q[wb_tag] && (wb_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_value = wb_value;
    end
`endif
  end

endmodule
